// File: rtl/sha_multiblock_ctrl.sv
// Multi-block sequencing controller: loads 16-word blocks into sche, paces comp through ROUNDS rounds, chains blocks.
// Optional watchdog abort is enabled by defining CTRL_TIMEOUT_EN.
module sha_multiblock_ctrl #(
  parameter int WORD_W         = 32,
  parameter int ROUNDS         = 64,
  parameter int BLOCK_WORDS    = 16,
  parameter int NBLK_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int RND_W         = $clog2(ROUNDS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NBLK_W-1:0] num_blocks,
  input  logic [WORD_W-1:0] wrapper_data,
  input  logic              wrapper_data_valid,
  output logic              wrapper_data_request,
  output logic [WORD_W-1:0] message_word_in,
  output logic [3:0]        message_word_addr,
  output logic              write_enable_in,
  output logic              start_to_sche,
  output logic              start_to_comp,
  output logic              first_block,
  output logic [RND_W-1:0]  round_t,
  input  logic [WORD_W-1:0] Wt_from_sche,
  output logic [WORD_W-1:0] Wt_to_comp,
  input  logic              STN_from_comp,
  output logic              STN_to_sche,
  input  logic              done_from_comp,
  output logic [NBLK_W-1:0] block_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_KICK      = 3'd2;
  localparam logic [2:0] S_ROUND     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  localparam logic [3:0]       LP_LAST_WORD = 4'(BLOCK_WORDS - 1);
  localparam logic [RND_W-1:0] LP_LAST_RND  = RND_W'(ROUNDS - 1);

  logic [2:0]        r_state;
  logic [NBLK_W-1:0] r_nblk;
  logic [3:0]        r_load_cnt;
  logic              r_req;
  logic [WORD_W-1:0] r_wdata;
  logic [3:0]        r_waddr;
  logic              r_we;
  logic              r_sts;
  logic              r_stc;
  logic              r_first;
  logic [RND_W-1:0]  r_round;
  logic [WORD_W-1:0] r_wt;
  logic [NBLK_W-1:0] r_bidx;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_last_word;
  logic              w_stn_round;
  logic              w_last_round;
  logic              w_done_wait;
  logic [NBLK_W-1:0] w_nblk_m1;
  logic              w_last_block;
  logic              w_timeout;
  logic [2:0]        w_state_fsm;
  logic [2:0]        w_state_nxt;

  assign w_start_ok   = (r_state == S_IDLE) && start && (num_blocks != '0);
  assign w_accept     = (r_state == S_LOAD) && r_req && wrapper_data_valid;
  assign w_last_word  = w_accept && (r_load_cnt == LP_LAST_WORD);
  assign w_stn_round  = (r_state == S_ROUND) && STN_from_comp;
  assign w_last_round = w_stn_round && (r_round == LP_LAST_RND);
  assign w_done_wait  = (r_state == S_WAIT_DONE) && done_from_comp;
  assign w_nblk_m1    = r_nblk - NBLK_W'(1);
  assign w_last_block = (r_bidx == w_nblk_m1);

  always_comb begin
    w_state_fsm = r_state;
    case (r_state)
      S_IDLE:      if (w_start_ok) w_state_fsm = S_LOAD;
      S_LOAD:      if (w_last_word) w_state_fsm = S_KICK;
      S_KICK:      w_state_fsm = S_ROUND;
      S_ROUND:     if (w_last_round) w_state_fsm = S_WAIT_DONE;
      S_WAIT_DONE: if (done_from_comp) w_state_fsm = w_last_block ? S_FINISH : S_LOAD;
      S_FINISH:    w_state_fsm = S_IDLE;
      default:     w_state_fsm = S_IDLE;
    endcase
  end

  assign w_state_nxt = w_timeout ? S_IDLE : w_state_fsm;

`ifdef CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] LP_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_wdog;
  logic             w_counting;
  logic             w_progress;

  assign w_counting = (r_state == S_LOAD) || (r_state == S_ROUND) || (r_state == S_WAIT_DONE);
  assign w_progress = w_accept || STN_from_comp || done_from_comp || (w_state_fsm != r_state);
  assign w_timeout  = w_counting && !w_progress && (r_wdog == LP_TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (!w_counting || w_progress || w_timeout) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + TMO_W'(1);
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_nblk     <= '0;
      r_load_cnt <= '0;
      r_req      <= 1'b0;
      r_wdata    <= '0;
      r_waddr    <= '0;
      r_we       <= 1'b0;
      r_sts      <= 1'b0;
      r_stc      <= 1'b0;
      r_first    <= 1'b0;
      r_round    <= '0;
      r_wt       <= '0;
      r_bidx     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_LOAD);
      r_we    <= w_accept;
      r_sts   <= w_last_word;
      r_stc   <= w_last_word;
      r_done  <= w_done_wait && w_last_block;
      r_err   <= w_timeout;

      if (w_start_ok) begin
        r_nblk     <= num_blocks;
        r_bidx     <= '0;
        r_first    <= 1'b1;
        r_busy     <= 1'b1;
        r_load_cnt <= '0;
      end

      if (w_accept) begin
        r_wdata    <= wrapper_data;
        r_waddr    <= r_load_cnt;
        r_load_cnt <= r_load_cnt + 4'd1;
      end

      // Round index restarts as the block is kicked and freezes at ROUNDS afterwards.
      if (w_last_word) begin
        r_round <= '0;
      end else if (w_stn_round) begin
        r_wt    <= Wt_from_sche;
        r_round <= r_round + RND_W'(1);
      end

      if (w_done_wait) begin
        if (w_last_block) begin
          r_busy <= 1'b0;
        end else begin
          r_bidx     <= r_bidx + NBLK_W'(1);
          r_first    <= 1'b0;
          r_load_cnt <= '0;
        end
      end

      if (w_timeout) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign wrapper_data_request = r_req;
  assign message_word_in      = r_wdata;
  assign message_word_addr    = r_waddr;
  assign write_enable_in      = r_we;
  assign start_to_sche        = r_sts;
  assign start_to_comp        = r_stc;
  assign first_block          = r_first;
  assign round_t              = r_round;
  assign Wt_to_comp           = r_wt;
  assign STN_to_sche          = STN_from_comp;
  assign block_idx            = r_bidx;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign err                  = r_err;

endmodule

// File: tb/tb_sha_multiblock_ctrl.sv
// Directed bench for sha_multiblock_ctrl: a 32-bit/64-round instance and a 64-bit/80-round instance.
module tb_sha_multiblock_ctrl;

  localparam int AR = 64;
  localparam int BR = 80;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        a_start, a_wvalid, a_req, a_we, a_sts, a_stc, a_first;
  logic [7:0]  a_nblk, a_bidx;
  logic [31:0] a_wdata, a_mword, a_wt_in, a_wt_out;
  logic [3:0]  a_maddr;
  logic [6:0]  a_round;
  logic        a_stn, a_stn_sche, a_cdone, a_busy, a_done, a_err;

  logic        b_start, b_wvalid, b_req, b_we, b_sts, b_stc, b_first;
  logic [7:0]  b_nblk, b_bidx;
  logic [63:0] b_wdata, b_mword, b_wt_in, b_wt_out;
  logic [3:0]  b_maddr;
  logic [6:0]  b_round;
  logic        b_stn, b_stn_sche, b_cdone, b_busy, b_done, b_err;

  int n_cmp = 0;
  int n_bad = 0;
  int a_done_cnt = 0;

  always @(negedge clk) if (a_done === 1'b1) a_done_cnt++;

  sha_multiblock_ctrl #(
    .WORD_W(32), .ROUNDS(AR), .BLOCK_WORDS(16), .NBLK_W(8), .TIMEOUT_CYCLES(16)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .num_blocks(a_nblk),
    .wrapper_data(a_wdata), .wrapper_data_valid(a_wvalid), .wrapper_data_request(a_req),
    .message_word_in(a_mword), .message_word_addr(a_maddr), .write_enable_in(a_we),
    .start_to_sche(a_sts), .start_to_comp(a_stc), .first_block(a_first), .round_t(a_round),
    .Wt_from_sche(a_wt_in), .Wt_to_comp(a_wt_out), .STN_from_comp(a_stn), .STN_to_sche(a_stn_sche),
    .done_from_comp(a_cdone), .block_idx(a_bidx), .busy(a_busy), .done(a_done), .err(a_err)
  );

  sha_multiblock_ctrl #(
    .WORD_W(64), .ROUNDS(BR), .BLOCK_WORDS(16), .NBLK_W(8), .TIMEOUT_CYCLES(16)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .num_blocks(b_nblk),
    .wrapper_data(b_wdata), .wrapper_data_valid(b_wvalid), .wrapper_data_request(b_req),
    .message_word_in(b_mword), .message_word_addr(b_maddr), .write_enable_in(b_we),
    .start_to_sche(b_sts), .start_to_comp(b_stc), .first_block(b_first), .round_t(b_round),
    .Wt_from_sche(b_wt_in), .Wt_to_comp(b_wt_out), .STN_from_comp(b_stn), .STN_to_sche(b_stn_sche),
    .done_from_comp(b_cdone), .block_idx(b_bidx), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_chk_idle_zero(input string pfx);
    chk({pfx, "_busy"}, a_busy, 0);
    chk({pfx, "_req"}, a_req, 0);
    chk({pfx, "_we"}, a_we, 0);
    chk({pfx, "_addr"}, a_maddr, 0);
    chk({pfx, "_mword"}, a_mword, 0);
    chk({pfx, "_sts"}, a_sts, 0);
    chk({pfx, "_stc"}, a_stc, 0);
    chk({pfx, "_first"}, a_first, 0);
    chk({pfx, "_round"}, a_round, 0);
    chk({pfx, "_wt"}, a_wt_out, 0);
    chk({pfx, "_bidx"}, a_bidx, 0);
    chk({pfx, "_done"}, a_done, 0);
    chk({pfx, "_err"}, a_err, 0);
  endtask

  task automatic a_start_run(input logic [7:0] n);
    a_start = 1'b1;
    a_nblk  = n;
    tick();
    a_start = 1'b0;
    chk("start_busy", a_busy, 1);
    chk("start_req", a_req, 1);
    chk("start_bidx", a_bidx, 0);
    chk("start_first", a_first, 1);
  endtask

  // Feeds 16 words with valid every 'period' cycles, then pokes a stray valid during KICK.
  task automatic a_load(input logic [31:0] base, input int period, input logic exp_first, input logic [7:0] exp_bidx);
    int sent, seen, cyc;
    sent = 0;
    seen = 0;
    cyc  = 0;
    while (seen < 16 && cyc < 400) begin
      if (sent < 16 && (cyc % period) == 0) begin
        a_wdata  = base + sent;
        a_wvalid = 1'b1;
        sent++;
      end else begin
        a_wdata  = 32'hBAD0_0000;
        a_wvalid = 1'b0;
      end
      tick();
      cyc++;
      if (a_we === 1'b1) begin
        chk("wr_addr", a_maddr, seen);
        chk("wr_data", a_mword, base + seen);
        seen++;
      end
    end
    chk("wr_count", seen, 16);
    chk("kick_sche", a_sts, 1);
    chk("kick_comp", a_stc, 1);
    chk("kick_round", a_round, 0);
    chk("req_drop", a_req, 0);
    chk("blk_first", a_first, exp_first);
    chk("blk_idx", a_bidx, exp_bidx);
    a_wdata  = 32'hDEAD_BEEF;
    a_wvalid = 1'b1;
    tick();
    a_wvalid = 1'b0;
    chk("spurious_dropped", a_we, 0);
    chk("kick_one_cycle", a_sts, 0);
  endtask

  task automatic a_rounds(input logic [31:0] seed, input int n, input bit poke_start, input bit poke_done, input bit last_done);
    for (int i = 0; i < n; i++) begin
      a_wt_in = seed + i;
      a_stn   = 1'b1;
      if (poke_start && i == 20) begin a_start = 1'b1; a_nblk = 8'd5; end
      if (poke_done && i == 5) a_cdone = 1'b1;
      if (last_done && i == n - 1) a_cdone = 1'b1;
      if (i == 0) begin #1; chk("stn_comb", a_stn_sche, 1); end
      tick();
      a_stn   = 1'b0;
      a_start = 1'b0;
      a_cdone = 1'b0;
      chk("round_t", a_round, i + 1);
      chk("wt_to_comp", a_wt_out, seed + i);
    end
    if (n == AR) begin
      chk("wait_no_done", a_done, 0);
      chk("wait_busy", a_busy, 1);
      a_wt_in = 32'h7777_7777;
      a_stn   = 1'b1;
      tick();
      a_stn   = 1'b0;
      chk("wait_stn_round", a_round, AR);
      chk("wait_stn_wt", a_wt_out, seed + AR - 1);
    end
  endtask

  task automatic a_block_done(input bit last, input logic [7:0] next_idx);
    a_cdone = 1'b1;
    tick();
    a_cdone = 1'b0;
    if (last) begin
      chk("done_pulse", a_done, 1);
      chk("done_busy_low", a_busy, 0);
      tick();
      chk("done_one_cycle", a_done, 0);
    end else begin
      chk("reload_req", a_req, 1);
      chk("reload_bidx", a_bidx, next_idx);
      chk("reload_first", a_first, 0);
      chk("reload_no_done", a_done, 0);
    end
  endtask

  task automatic b_load();
    for (int i = 0; i < 16; i++) begin
      b_wdata  = 64'hF0E1_D2C3_0000_0000 + i;
      b_wvalid = 1'b1;
      tick();
      chk("b_wr_addr", b_maddr, i);
      chk("b_wr_data", b_mword, 64'hF0E1_D2C3_0000_0000 + i);
    end
    b_wvalid = 1'b0;
    chk("b_kick", b_sts, 1);
    tick();
  endtask

  initial begin
    int dc0;
    reset_n  = 1'b0;
    a_start = 0; a_nblk = 0; a_wdata = 0; a_wvalid = 0; a_wt_in = 0; a_stn = 0; a_cdone = 0;
    b_start = 0; b_nblk = 0; b_wdata = 0; b_wvalid = 0; b_wt_in = 0; b_stn = 0; b_cdone = 0;
    repeat (3) tick();
    a_chk_idle_zero("rst");
    chk("rst_b_busy", b_busy, 0);
    reset_n = 1'b1;
    tick();

    // Zero-block start is ignored.
    a_start = 1'b1;
    a_nblk  = 8'd0;
    tick();
    a_start = 1'b0;
    chk("nblk0_busy", a_busy, 0);
    chk("nblk0_req", a_req, 0);

    // Single block, final STN coinciding with done_from_comp.
    dc0 = a_done_cnt;
    a_start_run(8'd1);
    a_load(32'h0000_0000, 1, 1'b1, 8'd0);
    a_rounds(32'hA500_0000, AR, 1'b0, 1'b0, 1'b1);
    a_block_done(1'b1, 8'd0);
    chk("single_first_held", a_first, 1);
    chk("single_done_count", a_done_cnt - dc0, 1);

    // Three chained blocks.
    dc0 = a_done_cnt;
    a_start_run(8'd3);
    for (int b = 0; b < 3; b++) begin
      a_load(32'h0001_0000 * b, 1, (b == 0), 8'(b));
      a_rounds(32'h1100_0000 + 32'h100 * b, AR, 1'b0, (b == 1), 1'b0);
      a_block_done((b == 2), 8'(b + 1));
    end
    chk("chain_done_count", a_done_cnt - dc0, 1);
    chk("chain_bidx_held", a_bidx, 2);

    // Stalled wrapper plus a start pulse during ROUND.
    dc0 = a_done_cnt;
    a_start_run(8'd1);
    a_load(32'h0000_1000, 3, 1'b1, 8'd0);
    a_rounds(32'h3300_0000, AR, 1'b1, 1'b0, 1'b0);
    a_nblk = 8'd1;
    a_block_done(1'b1, 8'd0);
    chk("stall_bidx", a_bidx, 0);
    chk("stall_done_count", a_done_cnt - dc0, 1);

    // Asynchronous reset at round 30 of block 1.
    a_start_run(8'd2);
    a_load(32'h0000_2000, 1, 1'b1, 8'd0);
    a_rounds(32'h4400_0000, AR, 1'b0, 1'b0, 1'b0);
    a_block_done(1'b0, 8'd1);
    a_load(32'h0000_3000, 1, 1'b0, 8'd1);
    a_rounds(32'h5500_0000, 30, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    a_chk_idle_zero("async_rst");
    tick();
    reset_n = 1'b1;
    tick();
    dc0 = a_done_cnt;
    a_start_run(8'd1);
    a_load(32'h0000_4000, 1, 1'b1, 8'd0);
    a_rounds(32'h6600_0000, AR, 1'b0, 1'b0, 1'b0);
    a_block_done(1'b1, 8'd0);
    chk("post_rst_done_count", a_done_cnt - dc0, 1);

    // 64-bit words, 80 rounds.
    b_start = 1'b1;
    b_nblk  = 8'd1;
    tick();
    b_start = 1'b0;
    chk("b_busy", b_busy, 1);
    b_load();
    for (int i = 0; i < BR; i++) begin
      b_wt_in = 64'hFEDC_BA98_0000_0000 | 64'(i);
      b_stn   = 1'b1;
      tick();
      b_stn   = 1'b0;
      chk("b_round_t", b_round, i + 1);
      chk("b_wt_to_comp", b_wt_out, 64'hFEDC_BA98_0000_0000 | 64'(i));
    end
    chk("b_round_max", b_round, 80);
    b_cdone = 1'b1;
    tick();
    b_cdone = 1'b0;
    chk("b_done", b_done, 1);
    chk("b_busy_low", b_busy, 0);
    tick();

    // Comp stalls after round 10.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_load();
    for (int i = 0; i < 10; i++) begin
      b_wt_in = 64'(i);
      b_stn   = 1'b1;
      tick();
      b_stn   = 1'b0;
    end
    chk("b_stall_round", b_round, 10);
    repeat (15) tick();
    chk("b_err_not_yet", b_err, 0);
    tick();
`ifdef CTRL_TIMEOUT_EN
    chk("b_err_pulse", b_err, 1);
    chk("b_tmo_busy", b_busy, 0);
    chk("b_tmo_done", b_done, 0);
    chk("b_tmo_req", b_req, 0);
    tick();
    chk("b_err_one_cycle", b_err, 0);
    chk("b_tmo_no_done", b_done, 0);
`else
    chk("b_no_err", b_err, 0);
    chk("b_still_busy", b_busy, 1);
    repeat (24) tick();
    chk("b_no_err_late", b_err, 0);
    chk("b_still_busy_late", b_busy, 1);
    chk("b_no_done_late", b_done, 0);
`endif
    chk("a_err_never", a_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
